tot_fine_pattern_gen: RTL and testbench
=======================================

# tot_fine_pattern_gen

Synthesizes the 63-tap raw delay-line snapshot that a given 6-bit TOT fine code represents. It also produces the 32-bit even-tap word the fine encoder consumes. It is the inverse of the TOT fine encoder: it serves as the on-chip/bench stimulus source for encoder self-test and sits ahead of the encoder's `encode_In` in the TDC test path. It supports single-code loads via a valid/ready handshake and an autonomous 64-code sweep.

## Interface
- `HOLD_W`, 8, width of the per-step hold counter in sweep mode
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `code_in`  in  6  fine code {polarity, pos[4:0]}
- `code_valid`  in  1  code_in valid
- `code_ready`  out  1  block accepts a code (high only in IDLE)
- `sweep_start`  in  1  start a 0..63 sweep (sampled in IDLE only)
- `hold_cycles`  in  HOLD_W  cycles per sweep step; 0 is treated as 1; sampled at sweep start
- `raw_out`  out  63  raw delay-line pattern
- `tot_out`  out  32  even taps of raw_out: tot_out[k] = raw_out[2k]
- `code_out`  out  6  code corresponding to raw_out (bubble not reflected)
- `out_valid`  out  1  one-cycle pulse: new pattern on outputs
- `busy`  out  1  high in SWEEP and DONE
- `sweep_done`  out  1  one-cycle pulse at end of sweep
- `bubble_en`, `bubble_tap[5:0]`  in  present only with TDC_FINE_BUBBLE_EN (see Configuration)

## Operation
- Pattern rule for code {p, pos}:
  - e = 2·pos (0..62).
  - For i ≥ e: raw[i] = p ^ ((i−e) mod 2).
  - For i < e: raw[i] = p ^ ((e−1−i) mod 2).
  - Result: exactly one equal-adjacent pair, at taps (e−1, e), when e > 0. For e = 0 the word is pure alternating, with raw[0] = p.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - code_valid & code_ready loads the pattern, code_out = code_in, and pulses out_valid. The state stays IDLE.
  - sweep_start: load code 0, latch H = max(hold_cycles, 1), go to SWEEP.
  - sweep_start has priority over a simultaneous code_valid; that code is not accepted.
- SWEEP:
  - The hold counter counts H cycles per code.
  - On expiry with code < 63: load code+1 and pulse out_valid.
  - On expiry with code = 63: go to DONE; outputs hold code 63.
  - sweep_start and code_valid are ignored.
- DONE: sweep_done = 1 for one cycle, then IDLE.
- Reset mid-operation aborts any sweep; all registers return to reset values on the same edge.

## Timing
- All outputs are registered except code_ready, which equals (state == IDLE).
- Latency: code accepted at edge k → raw_out/tot_out/code_out updated at edge k and out_valid high during the cycle after edge k.
- Sweep: out_valid pulses 64 times, spaced exactly H cycles apart. The first pulse is in the cycle after the sweep_start edge. sweep_done is asserted H cycles after the code-63 pulse; busy falls in the following cycle.
- Back-to-back single loads sustain one code per cycle.
- Reset values:
  - raw_out = 63'h2AAA_AAAA_AAAA_AAAA (code 0).
  - tot_out = 0, code_out = 0.
  - out_valid = 0, busy = 0, sweep_done = 0.
  - code_ready = 1 (IDLE).

## Configuration
- `TDC_FINE_BUBBLE_EN` defined:
  - Adds ports bubble_en and bubble_tap.
  - When bubble_en is sampled high at a pattern load, raw_out[bubble_tap] is inverted; tot_out follows raw_out.
  - bubble_tap = 63 inverts nothing.
  - code_out is never affected.
- Not defined: the ports are absent, no inversion logic exists, and raw_out is always the pure pattern.

## Test plan
- Reset, then idle: raw_out = 63'h2AAA_AAAA_AAAA_AAAA, tot_out = 0, code_ready = 1, busy = 0, out_valid = 0.
- Single load of code 6'b0_00001 → next cycle out_valid = 1, raw_out = 63'h2AAA_AAAA_AAAA_AAA9, tot_out = 32'h0000_0001, code_out = 1.
- Single load of code 6'b1_11111 → raw_out = 63'h6AAA_AAAA_AAAA_AAAA, tot_out = 32'h8000_0000.
- Sweep with hold_cycles = 0 (H = 1) → 64 consecutive out_valid cycles, code_out = 0..63, sweep_done one cycle after code 63. Cross-check every step through the fine encoder: Binary_Out == code_out and errorFlag = 0.
- sweep_start and code_valid in the same cycle with hold_cycles = 3 → code not accepted, sweep runs with pulses 3 cycles apart. Reset asserted at code 10 → reset values on the next edge, code_ready = 1.
- With TDC_FINE_BUBBLE_EN: code 6'b0_00000, bubble_en = 1, bubble_tap = 4 → raw_out = 63'h2AAA_AAAA_AAAA_AABA, code_out = 0, and the encoder raises errorFlag.

Source files
------------

// File: rtl/tot_fine_pattern_gen.sv
// -----------------------------------------------------------------------------
// tot_fine_pattern_gen
// Builds the 63-tap raw delay-line snapshot that a 6-bit TOT fine code
// {polarity, pos[4:0]} stands for, plus its 32-bit even-tap word. This is the
// inverse of the fine encoder and acts as its stimulus source. A code can be
// loaded through a valid/ready handshake, or the block can run an autonomous
// sweep over all 64 codes.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   code_in/code_valid single-code load request
//   code_ready         accepting codes (IDLE only, combinational)
//   sweep_start        start a 0..63 sweep (IDLE only)
//   hold_cycles        cycles per sweep step, 0 behaves as 1, taken at start
//   raw_out            raw delay-line pattern
//   tot_out            even taps of raw_out
//   code_out           code that raw_out encodes (any bubble is not shown)
//   out_valid          one-cycle pulse when a new pattern is loaded
//   busy               high in SWEEP and DONE
//   sweep_done         one-cycle pulse when a sweep ends
//   bubble_en/_tap     only when TDC_FINE_BUBBLE_EN is defined: invert one tap
//
// Optional feature macro: TDC_FINE_BUBBLE_EN
// -----------------------------------------------------------------------------
module tot_fine_pattern_gen #(
    parameter int unsigned HOLD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        code_in,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic              sweep_start,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic [62:0]       raw_out,
    output logic [31:0]       tot_out,
    output logic [5:0]        code_out,
    output logic              out_valid,
    output logic              busy,
    output logic              sweep_done
`ifdef TDC_FINE_BUBBLE_EN
    ,
    input  logic              bubble_en,
    input  logic [5:0]        bubble_tap
`endif
);

    localparam int unsigned RAW_W  = 63;
    localparam int unsigned TOT_W  = 32;
    localparam int unsigned CODE_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state, next_state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_reload;
    logic [HOLD_W-1:0]   hold_start_c;
    logic                expire_c;
    logic                load_c;
    logic                start_c;
    logic [CODE_W-1:0]   load_code_c;
    logic [RAW_W-1:0]    bubble_mask_c;
    logic [RAW_W-1:0]    raw_next_c;
    logic [TOT_W-1:0]    tot_next_c;

    // Taps below e = 2*pos are phase-flipped relative to the alternating base,
    // which leaves the single equal-adjacent pair at (e-1, e).
    function automatic logic [RAW_W-1:0] pattern(input logic [CODE_W-1:0] code);
        logic [RAW_W-1:0]  r;
        logic [CODE_W-1:0] e;
        logic [CODE_W-1:0] idx;
        e = {code[4:0], 1'b0};
        for (int i = 0; i < int'(RAW_W); i++) begin
            idx  = CODE_W'(i);
            r[i] = code[5] ^ idx[0] ^ (idx < e);
        end
        return r;
    endfunction

    assign code_ready   = (state == ST_IDLE);
    assign expire_c     = (hold_cnt == '0);
    // Step counter reloads with H-1, so hold_cycles of 0 and 1 both give H = 1.
    assign hold_start_c = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);

`ifdef TDC_FINE_BUBBLE_EN
    // Tap 63 does not exist, so it selects no inversion.
    assign bubble_mask_c = (bubble_en && (bubble_tap != 6'd63))
                         ? (RAW_W'(1) << bubble_tap) : '0;
`else
    assign bubble_mask_c = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (sweep_start) next_state = ST_SWEEP;
            ST_SWEEP: if (expire_c && (code_out == 6'd63)) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Load decisions; sweep_start wins over a simultaneous code_valid.
    always_comb begin
        load_c      = 1'b0;
        start_c     = 1'b0;
        load_code_c = code_out;
        case (state)
            ST_IDLE: begin
                if (sweep_start) begin
                    load_c      = 1'b1;
                    start_c     = 1'b1;
                    load_code_c = '0;
                end else if (code_valid) begin
                    load_c      = 1'b1;
                    load_code_c = code_in;
                end
            end
            ST_SWEEP: begin
                if (expire_c && (code_out != 6'd63)) begin
                    load_c      = 1'b1;
                    load_code_c = CODE_W'(code_out + 6'd1);
                end
            end
            default: ;
        endcase
    end

    // Pattern and its even-tap word for the code about to be loaded.
    always_comb begin
        raw_next_c = pattern(load_code_c) ^ bubble_mask_c;
        tot_next_c = '0;
        for (int k = 0; k < int'(TOT_W); k++) begin
            tot_next_c[k] = raw_next_c[2*k];
        end
    end

    // Registered outputs and sweep step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_out     <= 63'h2AAA_AAAA_AAAA_AAAA;
            tot_out     <= '0;
            code_out    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            hold_cnt    <= '0;
            hold_reload <= '0;
        end else begin
            out_valid  <= load_c;
            busy       <= (next_state != ST_IDLE);
            sweep_done <= (state == ST_SWEEP) && (next_state == ST_DONE);
            if (start_c) begin
                hold_reload <= hold_start_c;
                hold_cnt    <= hold_start_c;
            end else if (state == ST_SWEEP) begin
                hold_cnt <= expire_c ? hold_reload : hold_cnt - HOLD_W'(1);
            end
            if (load_c) begin
                raw_out  <= raw_next_c;
                tot_out  <= tot_next_c;
                code_out <= load_code_c;
            end
        end
    end

endmodule

// File: tb/tb_tot_fine_pattern_gen.sv
module tb_tot_fine_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  code_in;
    logic        code_valid;
    logic        code_ready;
    logic        sweep_start;
    logic [7:0]  hold_cycles;
    logic [62:0] raw_out;
    logic [31:0] tot_out;
    logic [5:0]  code_out;
    logic        out_valid;
    logic        busy;
    logic        sweep_done;
`ifdef TDC_FINE_BUBBLE_EN
    logic        bubble_en;
    logic [5:0]  bubble_tap;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [62:0] RAW_CODE0 = 63'h2AAA_AAAA_AAAA_AAAA;

    always #5 clk = ~clk;

    tot_fine_pattern_gen #(.HOLD_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .code_in     (code_in),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .sweep_start (sweep_start),
        .hold_cycles (hold_cycles),
        .raw_out     (raw_out),
        .tot_out     (tot_out),
        .code_out    (code_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .sweep_done  (sweep_done)
`ifdef TDC_FINE_BUBBLE_EN
        ,
        .bubble_en   (bubble_en),
        .bubble_tap  (bubble_tap)
`endif
    );

    task automatic chk(input string tag, input logic [62:0] obs, input logic [62:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference pattern written directly from the tap formulas.
    function automatic logic [62:0] ref_pattern(input logic [5:0] code);
        logic [62:0] r;
        int e;
        e = 2 * int'(code[4:0]);
        for (int i = 0; i < 63; i++) begin
            if (i >= e) r[i] = code[5] ^ logic'((i - e) % 2);
            else        r[i] = code[5] ^ logic'((e - 1 - i) % 2);
        end
        return r;
    endfunction

    // Encoder model: locate the equal-adjacent pair and rebuild the code.
    function automatic logic [6:0] ref_encode(input logic [62:0] r);
        int pairs;
        int at;
        int e;
        logic err;
        logic [5:0] pos;
        pairs = 0;
        at    = 0;
        for (int j = 1; j < 63; j++) begin
            if (r[j] == r[j-1]) begin
                pairs++;
                at = j;
            end
        end
        err = (pairs > 1) || ((pairs == 1) && (at % 2 == 1));
        e   = (pairs == 1) ? at : 0;
        pos = 6'(e / 2);
        return {err, r[e], pos[4:0]};
    endfunction

    logic [62:0] raw_even_tot;
    logic [6:0]  enc;

    initial begin
        reset       = 1'b1;
        code_in     = '0;
        code_valid  = 1'b0;
        sweep_start = 1'b0;
        hold_cycles = '0;
`ifdef TDC_FINE_BUBBLE_EN
        bubble_en   = 1'b0;
        bubble_tap  = '0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset / idle values
        chk("rst_raw",   raw_out, RAW_CODE0);
        chk("rst_tot",   63'(tot_out), 63'(0));
        chk("rst_code",  63'(code_out), 63'(0));
        chk("rst_ready", 63'(code_ready), 63'(1));
        chk("rst_busy",  63'(busy), 63'(0));
        chk("rst_valid", 63'(out_valid), 63'(0));
        chk("rst_done",  63'(sweep_done), 63'(0));

        // Back-to-back single loads: code 1 then code 63
        code_in = 6'b0_00001; code_valid = 1'b1;
        @(negedge clk);
        chk("ld1_valid", 63'(out_valid), 63'(1));
        chk("ld1_raw",   raw_out, 63'h2AAA_AAAA_AAAA_AAA9);
        chk("ld1_tot",   63'(tot_out), 63'(32'h0000_0001));
        chk("ld1_code",  63'(code_out), 63'(1));
        code_in = 6'b1_11111;
        @(negedge clk);
        chk("ld63_valid", 63'(out_valid), 63'(1));
        chk("ld63_raw",   raw_out, 63'h6AAA_AAAA_AAAA_AAAA);
        chk("ld63_tot",   63'(tot_out), 63'(32'h8000_0000));
        chk("ld63_code",  63'(code_out), 63'(63));
        code_valid = 1'b0;
        @(negedge clk);
        chk("idle_valid", 63'(out_valid), 63'(0));
        chk("idle_hold",  raw_out, 63'h6AAA_AAAA_AAAA_AAAA);

        // Sweep with hold_cycles = 0 (one code per cycle)
        hold_cycles = 8'd0; sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        chk("sw_busy",  63'(busy), 63'(1));
        chk("sw_ready", 63'(code_ready), 63'(0));
        for (int k = 0; k < 64; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("sw_valid_%0d", k), 63'(out_valid), 63'(1));
            chk($sformatf("sw_code_%0d", k), 63'(code_out), 63'(k));
            chk($sformatf("sw_raw_%0d", k), raw_out, ref_pattern(6'(k)));
            raw_even_tot = '0;
            for (int t = 0; t < 32; t++) raw_even_tot[t] = raw_out[2*t];
            chk($sformatf("sw_tot_%0d", k), 63'(tot_out), raw_even_tot);
            enc = ref_encode(raw_out);
            chk($sformatf("sw_enc_%0d", k), 63'(enc), 63'({1'b0, 6'(k)}));
            chk($sformatf("sw_nodone_%0d", k), 63'(sweep_done), 63'(0));
        end
        @(negedge clk);
        chk("sw_done",      63'(sweep_done), 63'(1));
        chk("sw_done_busy", 63'(busy), 63'(1));
        chk("sw_done_nov",  63'(out_valid), 63'(0));
        chk("sw_done_code", 63'(code_out), 63'(63));
        @(negedge clk);
        chk("sw_end_done",  63'(sweep_done), 63'(0));
        chk("sw_end_busy",  63'(busy), 63'(0));
        chk("sw_end_ready", 63'(code_ready), 63'(1));

        // sweep_start beats code_valid; H = 3; code_valid ignored while sweeping
        hold_cycles = 8'd3; sweep_start = 1'b1; code_valid = 1'b1; code_in = 6'd45;
        @(negedge clk);
        sweep_start = 1'b0; hold_cycles = 8'd7;
        chk("pri_code",  63'(code_out), 63'(0));
        chk("pri_valid", 63'(out_valid), 63'(1));
        chk("pri_raw",   raw_out, RAW_CODE0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("h3_gap1_%0d", k), 63'(out_valid), 63'(0));
            @(negedge clk);
            chk($sformatf("h3_gap2_%0d", k), 63'(out_valid), 63'(0));
            @(negedge clk);
            chk($sformatf("h3_valid_%0d", k), 63'(out_valid), 63'(1));
            chk($sformatf("h3_code_%0d", k), 63'(code_out), 63'(k));
        end
        chk("h3_busy10", 63'(busy), 63'(1));
        code_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_raw",   raw_out, RAW_CODE0);
        chk("abort_tot",   63'(tot_out), 63'(0));
        chk("abort_code",  63'(code_out), 63'(0));
        chk("abort_ready", 63'(code_ready), 63'(1));
        chk("abort_busy",  63'(busy), 63'(0));
        chk("abort_valid", 63'(out_valid), 63'(0));
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_stay_valid", 63'(out_valid), 63'(0));
        chk("abort_stay_code",  63'(code_out), 63'(0));

`ifdef TDC_FINE_BUBBLE_EN
        // Bubble at tap 4 on code 0
        code_in = 6'b0_00000; code_valid = 1'b1; bubble_en = 1'b1; bubble_tap = 6'd4;
        @(negedge clk);
        chk("bub_raw",  raw_out, 63'h2AAA_AAAA_AAAA_AABA);
        chk("bub_code", 63'(code_out), 63'(0));
        chk("bub_tot",  63'(tot_out), 63'(32'h0000_0004));
        enc = ref_encode(raw_out);
        chk("bub_err",  63'(enc[6]), 63'(1));
        bubble_tap = 6'd63;
        @(negedge clk);
        chk("bub63_raw", raw_out, RAW_CODE0);
        code_valid = 1'b0; bubble_en = 1'b0;
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
